// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared width, divider state encoding and divide-by-zero quotient
package mips_alu_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
  localparam logic signed [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/mips_div_seq_if.sv
// mips_div_seq_if: execute-stage handshake and result bus of the sequential divider
interface mips_div_seq_if import mips_alu_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  modport master (output start, is_signed, dividend, divisor,
                  input busy, done, div_by_zero, quotient, remainder);
  modport slave (input start, is_signed, dividend, divisor,
                 output busy, done, div_by_zero, quotient, remainder);
endinterface

// File: rtl/cla_sub_w.sv
// cla_sub_w: a - b as a + ~b + 1 using 4-bit CLA slices and a second-layer group lookahead
module cla_sub_w import mips_alu_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);
  localparam int N = WIDTH / 4;
  logic [WIDTH-1:0] g, p, c;
  logic [N-1:0]     gg, gp;
  logic [N:0]       gc;
  assign g = a & ~b;
  assign p = a ^ ~b;
  for (genvar i = 0; i < N; i++) begin : g_slice
    logic [3:0] sg, sp;
    assign sg         = g[4*i +: 4];
    assign sp         = p[4*i +: 4];
    assign c[4*i]     = gc[i];
    assign c[4*i+1]   = sg[0] | sp[0] & gc[i];
    assign c[4*i+2]   = sg[1] | sp[1] & sg[0] | sp[1] & sp[0] & gc[i];
    assign c[4*i+3]   = sg[2] | sp[2] & sg[1] | sp[2] & sp[1] & sg[0] | sp[2] & sp[1] & sp[0] & gc[i];
    assign gg[i]      = sg[3] | sp[3] & sg[2] | sp[3] & sp[2] & sg[1] | sp[3] & sp[2] & sp[1] & sg[0];
    assign gp[i]      = &sp;
  end
  // carry-in of 1 completes the two's-complement of b
  always_comb begin
    gc[0] = 1'b1;
    for (int k = 0; k < N; k++) gc[k+1] = gg[k] | gp[k] & gc[k];
  end
  assign diff = p ^ c;
  assign cout = gc[N];
endmodule

// File: rtl/mips_div_seq.sv
// mips_div_seq: multi-cycle restoring DIV/DIVU, one quotient bit per clock
module mips_div_seq import mips_alu_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input logic           clk,
  input logic           rst_n,
  mips_div_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, q_out_q, q_out_d, r_out_q, r_out_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, dz_out_q, dz_out_d;
  logic [WIDTH-1:0] rem_sh, sa_a, sa_b, sa_diff, sb_b, sb_diff;
  logic             sa_cout, unused_cout, no_borrow, a_neg, b_neg;
  // one subtractor serves abs(dividend), the trial subtract and quotient negation; the other abs(divisor) and remainder negation
  assign rem_sh    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign sa_a      = state_q == RUN ? rem_sh : '0;
  assign sa_b      = state_q == RUN ? dvs_q : state_q == FIX ? quo_q : bus.dividend;
  assign sb_b      = state_q == FIX ? rem_q : bus.divisor;
  assign no_borrow = sa_cout | rem_q[WIDTH-1];
  assign a_neg     = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg     = bus.is_signed & bus.divisor[WIDTH-1];
  cla_sub_w #(.WIDTH(WIDTH)) u_sub_a (.a(sa_a), .b(sa_b), .diff(sa_diff), .cout(sa_cout));
  cla_sub_w #(.WIDTH(WIDTH)) u_sub_b (.a('0), .b(sb_b), .diff(sb_diff), .cout(unused_cout));
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dz_out_d = dz_out_q;
    if (state_q == IDLE && bus.start) begin
      dz_d    = bus.divisor == '0;
      qneg_d  = a_neg ^ b_neg;
      rneg_d  = a_neg;
      quo_d   = a_neg ? sa_diff : bus.dividend;
      dvs_d   = b_neg ? sb_diff : bus.divisor;
      rem_d   = dz_d ? bus.dividend : '0;
      cnt_d   = CNT_W'(WIDTH);
      state_d = dz_d ? FIX : RUN;
    end else if (state_q == RUN) begin
      rem_d   = no_borrow ? sa_diff : rem_sh;
      quo_d   = {quo_q[WIDTH-2:0], no_borrow};
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == CNT_W'(1) ? FIX : RUN;
    end else if (state_q == FIX) begin
      q_out_d  = dz_q ? WIDTH'(DIV0_QUOTIENT) : qneg_q ? sa_diff : quo_q;
      r_out_d  = rneg_q && !dz_q ? sb_diff : rem_q;
      dz_out_d = dz_q;
      state_d  = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dz_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
      dz_out_q <= dz_out_d;
    end
  end
  assign bus.busy        = state_q == RUN || state_q == FIX;
  assign bus.done        = state_q == DONE;
  assign bus.div_by_zero = dz_out_q;
  assign bus.quotient    = q_out_q;
  assign bus.remainder   = r_out_q;
endmodule

// File: tb/tb_mips_div_seq.sv
// tb_mips_div_seq: directed self-checking bench for the sequential divider
module tb_mips_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  mips_div_seq_if #(.WIDTH(32)) bus();
  mips_div_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  // leaves the bench in cycle 1 (the start was sampled at the end of cycle 0)
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    bus.dividend = a; bus.divisor = b; bus.is_signed = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done;
    while (!bus.done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    #22;
    n_tests++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset got busy=%b done=%b dz=%b q=%h r=%h exp all zero", bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_divu;
    issue(32'd100, 32'd7, 1'b0);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL divu_busy got %b exp 1", bus.busy); end
    wait_done;
    n_tests++;
    if (cyc !== 34) begin n_fail++; $display("FAIL divu_latency got %0d exp 34", cyc); end
    n_tests++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.busy} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL divu_result got q=%h r=%h dz=%b busy=%b exp q=0000000e r=00000002 dz=0 busy=0", bus.quotient, bus.remainder, bus.div_by_zero, bus.busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.done, bus.quotient} !== {1'b0, 32'd14}) begin
      n_fail++;
      $display("FAIL divu_pulse got done=%b q=%h exp done=0 q=0000000e", bus.done, bus.quotient);
    end
  endtask

  task automatic test_signed;
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done;
    n_tests++;
    if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL div_neg_dividend got q=%h r=%h exp q=fffffffd r=ffffffff", bus.quotient, bus.remainder);
    end
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done;
    n_tests++;
    if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFD, 32'd1}) begin
      n_fail++;
      $display("FAIL div_neg_divisor got q=%h r=%h exp q=fffffffd r=00000001", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_overflow;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done;
    n_tests++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'h8000_0000, 32'd0, 1'b0} || cyc !== 34) begin
      n_fail++;
      $display("FAIL div_overflow got q=%h r=%h dz=%b cyc=%0d exp q=80000000 r=00000000 dz=0 cyc=34", bus.quotient, bus.remainder, bus.div_by_zero, cyc);
    end
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done;
    n_tests++;
    if ({bus.quotient, bus.remainder} !== {32'd0, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL divu_big got q=%h r=%h exp q=00000000 r=80000000", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_div_zero;
    issue(32'h1234_5678, 32'd0, 1'b0);
    wait_done;
    n_tests++;
    if (cyc !== 2) begin n_fail++; $display("FAIL dz_latency got %0d exp 2", cyc); end
    n_tests++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) begin
      n_fail++;
      $display("FAIL dz_result got q=%h r=%h dz=%b exp q=ffffffff r=12345678 dz=1", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    issue(32'd9, 32'd3, 1'b0);
    n_tests++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) begin
      n_fail++;
      $display("FAIL dz_hold got q=%h r=%h dz=%b exp q=ffffffff r=12345678 dz=1", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    wait_done;
    n_tests++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'd3, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL dz_clear got q=%h r=%h dz=%b exp q=00000003 r=00000000 dz=0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    issue(32'd1000, 32'd10, 1'b0);
    while (!bus.done && cyc < 60) begin
      if (cyc == 10) begin bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 32'd5; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    n_tests++;
    if ({bus.quotient, bus.remainder} !== {32'd100, 32'd0} || cyc !== 34) begin
      n_fail++;
      $display("FAIL ignore_start got q=%h r=%h cyc=%0d exp q=00000064 r=00000000 cyc=34", bus.quotient, bus.remainder, cyc);
    end
    issue(32'd5, 32'd5, 1'b0);
    wait_done;
    n_tests++;
    if ({bus.quotient, bus.remainder} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL back_to_back got q=%h r=%h exp q=00000001 r=00000000", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    issue(32'hFFFF_FFFF, 32'd3, 1'b0);
    while (cyc < 15) begin @(posedge clk); #1; cyc++; end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 67'd0) begin
      n_fail++;
      $display("FAIL abort_clear got busy=%b done=%b dz=%b q=%h r=%h exp all zero", bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= bus.done | bus.busy; end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got activity=%b exp 0", seen); end
    issue(32'd9, 32'd4, 1'b0);
    wait_done;
    n_tests++;
    if ({bus.quotient, bus.remainder} !== {32'd2, 32'd1} || cyc !== 34) begin
      n_fail++;
      $display("FAIL abort_recover got q=%h r=%h cyc=%0d exp q=00000002 r=00000001 cyc=34", bus.quotient, bus.remainder, cyc);
    end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_signed;
    test_overflow;
    test_div_zero;
    test_ignore_start;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
